// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state enum, special opcodes and default program entry points.
package fetch_pkg;

    localparam int FETCH_PC_W    = 8;
    localparam int FETCH_INSTR_W = 8;

    localparam logic [FETCH_INSTR_W-1:0] HALT_OP    = 8'b1000_1000;
    localparam logic [FETCH_INSTR_W-1:0] ILLEGAL_OP = 8'hFF;

    localparam int DEF_PROG0_BASE = 0;
    localparam int DEF_PROG1_BASE = 93;
    localparam int DEF_PROG2_BASE = 142;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction ROM bus between the fetch stage (master) and the ROM (slave).
// pc: fetch address to ROM; instr: combinational ROM read data back.
interface pc_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);

    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;

    modport master (
        output pc,
        input  instr
    );

    modport slave (
        input  pc,
        output instr
    );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential increment or relative branch from PC+1.
// Ports: pc_i, branch_i, branch_back_i, branch_off_i in; pc_next_o out (mod 2^PC_W).
module pc_next_calc #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            branch_i,
    input  logic            branch_back_i,
    input  logic [PC_W-1:0] branch_off_i,
    output logic [PC_W-1:0] pc_next_o
);

    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_i + PC_W'(1);

    always_comb begin
        pc_next_o = pc_inc;
        unique case (1'b1)
            !branch_i:
                pc_next_o = pc_inc;
            branch_i && !branch_back_i:
                pc_next_o = pc_inc + branch_off_i;
            branch_i && branch_back_i:
                pc_next_o = pc_inc - branch_off_i;
            default:
                pc_next_o = pc_inc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, launches resident programs, follows branches, stops on halt.
// Ports: clk_i, rst_ni, start_i, prog_sel_i, stall_i, branch_i/_back_i/_off_i in;
//   rom (master: pc out, instr in), instr_o, instr_valid_o, busy_o, done_o, err_o, count_o out.
// Optional macro FETCH_ILLEGAL_TRAP_EN: 8'hFF fetch traps to ERROR and raises err_o.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W       = FETCH_PC_W,
    parameter int INSTR_W    = FETCH_INSTR_W,
    parameter int PROG0_BASE = DEF_PROG0_BASE,
    parameter int PROG1_BASE = DEF_PROG1_BASE,
    parameter int PROG2_BASE = DEF_PROG2_BASE,
    parameter int CNT_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [1:0]          prog_sel_i,
    input  logic                stall_i,
    input  logic                branch_i,
    input  logic                branch_back_i,
    input  logic [PC_W-1:0]     branch_off_i,
    pc_fetch_unit_if.master     rom,
    output logic [INSTR_W-1:0]  instr_o,
    output logic                instr_valid_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [CNT_W-1:0]    count_o
);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, pc_nxt, base_pc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             is_halt, is_ill, issue, launch, trap;

    assign is_halt = (rom.instr == INSTR_W'(HALT_OP));

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign is_ill = (rom.instr == INSTR_W'(ILLEGAL_OP));
`else
    assign is_ill = 1'b0;
`endif

    always_comb begin
        base_pc = PC_W'(PROG0_BASE);
        unique case (prog_sel_i)
            2'd1:    base_pc = PC_W'(PROG1_BASE);
            2'd2:    base_pc = PC_W'(PROG2_BASE);
            default: base_pc = PC_W'(PROG0_BASE);
        endcase
    end

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc_i          (pc_q),
        .branch_i      (branch_i),
        .branch_back_i (branch_back_i),
        .branch_off_i  (branch_off_i),
        .pc_next_o     (pc_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        launch  = 1'b0;
        trap    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!stall_i) begin
                    if (is_halt) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end else if (is_ill) begin
                        state_d = ST_ERROR;
                        done_d  = 1'b1;
                        trap    = 1'b1;
                    end else begin
                        issue = 1'b1;
                        pc_d  = pc_nxt;
                        // Counter saturates rather than wrapping.
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    pc_d    = base_pc;
                    cnt_d   = '0;
                    launch  = 1'b1;
                end
            end
        endcase
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (launch) begin
            err_q <= 1'b0;
        end else if (trap) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_ok;

    assign unused_ok = launch ^ trap;
    assign err_o     = 1'b0;
`endif

    assign rom.pc        = pc_q;
    assign instr_o       = issue ? rom.instr : '0;
    assign instr_valid_o = issue;
    assign busy_o        = (state_q == ST_RUN);
    assign done_o        = done_q;
    assign count_o       = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: ROM image, abstract reference model, per-cycle compare.
// Directed scenarios with literal checks pin the model at key points.
module tb_pc_fetch_unit;

    localparam int CW = 6;

`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start;
    logic [1:0] sel;
    logic       stall;
    logic       br;
    logic       back;
    logic [7:0] off;

    logic [7:0]    instr_o;
    logic          valid_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [CW-1:0] count_o;

    logic [7:0] rom [256];

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_unit_if #(.PC_W(8), .INSTR_W(8)) rom_bus ();

    assign rom_bus.instr = rom[rom_bus.pc];

    pc_fetch_unit #(
        .CNT_W (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .prog_sel_i    (sel),
        .stall_i       (stall),
        .branch_i      (br),
        .branch_back_i (back),
        .branch_off_i  (off),
        .rom           (rom_bus),
        .instr_o       (instr_o),
        .instr_valid_o (valid_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    // Reference model: running flag, PC, count, done pulse, sticky error.
    bit m_run  = 1'b0;
    int m_pc   = 0;
    int m_cnt  = 0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    function automatic int base_of(logic [1:0] s);
        case (s)
            2'd1:    return 93;
            2'd2:    return 142;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_issue();
        logic [7:0] ins;
        ins = rom[m_pc];
        return m_run && !stall && ins != 8'h88 && !(TRAP && ins == 8'hFF);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] ins;
        int delta;
        if (!rst_n) begin
            m_run  = 1'b0;
            m_pc   = 0;
            m_cnt  = 0;
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            ins = rom[m_pc];
            m_done = 1'b0;
            if (!m_run) begin
                if (start) begin
                    m_run = 1'b1;
                    m_pc  = base_of(sel);
                    m_cnt = 0;
                    m_err = 1'b0;
                end
            end else if (!stall) begin
                if (ins == 8'h88) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end else if (TRAP && ins == 8'hFF) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_err  = 1'b1;
                end else begin
                    delta = !br ? 0 : (back ? -int'(off) : int'(off));
                    m_pc  = (m_pc + 1 + delta + 512) % 256;
                    if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
                end
            end
        end
    end

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit iss;
        iss = m_issue();
        cmp("pc", 32'(rom_bus.pc), 32'(m_pc));
        cmp("busy", 32'(busy_o), 32'(m_run));
        cmp("valid", 32'(valid_o), 32'(iss));
        cmp("instr", 32'(instr_o), iss ? 32'(rom[m_pc]) : 32'd0);
        cmp("count", 32'(count_o), 32'(m_cnt));
        cmp("done", 32'(done_o), 32'(m_done));
        cmp("err", 32'(err_o), 32'(m_err));
    end

    task automatic drive(bit s, bit [1:0] ps, bit st, bit b, bit bk, bit [7:0] o);
        start = s;
        sel   = ps;
        stall = st;
        br    = b;
        back  = bk;
        off   = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(int target, int budget);
        int n;
        n = 0;
        drive(0, 0, 0, 0, 0, 0);
        while (int'(rom_bus.pc) != target && n < budget) begin
            tick();
            n++;
        end
        cmp("reach_pc", 32'(rom_bus.pc), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'((i * 7 + 3) & 8'h7F);
        rom[92]  = 8'h88;
        rom[198] = 8'hFF;
        rom[255] = 8'hFF;
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_pc", 32'(rom_bus.pc), 0);
        cmp("rst_busy", 32'(busy_o), 0);
        cmp("rst_count", 32'(count_o), 0);
        cmp("rst_valid", 32'(valid_o), 0);
        cmp("rst_done", 32'(done_o), 0);
        cmp("rst_err", 32'(err_o), 0);
        cmp("rst_instr", 32'(instr_o), 0);
        rst_n = 1'b1;

        drive(1, 1, 0, 0, 0, 0);
        tick();
        cmp("start1_pc", 32'(rom_bus.pc), 93);
        cmp("start1_busy", 32'(busy_o), 1);
        cmp("start1_count", 32'(count_o), 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        cmp("start_ignored_pc", 32'(rom_bus.pc), 94);

        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        cmp("async_pc", 32'(rom_bus.pc), 0);
        cmp("async_busy", 32'(busy_o), 0);
        cmp("async_count", 32'(count_o), 0);
        cmp("async_valid", 32'(valid_o), 0);
        cmp("async_instr", 32'(instr_o), 0);
        tick();
        rst_n = 1'b1;

        drive(1, 0, 0, 0, 0, 0);
        tick();
        cmp("start0_pc", 32'(rom_bus.pc), 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            cmp("seq_pc", 32'(rom_bus.pc), 32'(i));
            tick();
        end
        cmp("seq_count", 32'(count_o), 5);

        run_to(17, 40);
        drive(0, 0, 0, 1, 0, 6);
        tick();
        cmp("fwd_pc", 32'(rom_bus.pc), 24);
        run_to(47, 40);
        drive(0, 0, 0, 1, 1, 36);
        tick();
        cmp("back_pc", 32'(rom_bus.pc), 12);

        run_to(20, 40);
        cmp("pre_stall_count", 32'(count_o), 50);
        drive(0, 0, 1, 1, 0, 5);
        #1;
        cmp("stall_valid", 32'(valid_o), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("stall_pc", 32'(rom_bus.pc), 20);
            cmp("stall_count", 32'(count_o), 50);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        cmp("release_pc", 32'(rom_bus.pc), 21);
        cmp("release_count", 32'(count_o), 51);

        drive(0, 0, 0, 1, 1, 12);
        tick();
        cmp("back12_pc", 32'(rom_bus.pc), 10);
        drive(0, 0, 0, 1, 1, 20);
        tick();
        cmp("wrap_back_pc", 32'(rom_bus.pc), 247);
        run_to(250, 10);
        drive(0, 0, 0, 1, 0, 10);
        tick();
        cmp("wrap_fwd_pc", 32'(rom_bus.pc), 5);

        run_to(92, 120);
        #1;
        cmp("halt_valid", 32'(valid_o), 0);
        cmp("halt_instr", 32'(instr_o), 0);
        cmp("halt_busy", 32'(busy_o), 1);
        tick();
        cmp("halt_done", 32'(done_o), 1);
        cmp("halt_busy_off", 32'(busy_o), 0);
        cmp("halt_pc", 32'(rom_bus.pc), 92);
        cmp("sat_count", 32'(count_o), 63);
        tick();
        cmp("done_pulse_end", 32'(done_o), 0);

        drive(1, 2, 0, 0, 0, 0);
        tick();
        cmp("start2_pc", 32'(rom_bus.pc), 142);
        cmp("start2_count", 32'(count_o), 0);
        run_to(198, 80);
        #1;
`ifdef FETCH_ILLEGAL_TRAP_EN
        cmp("trap_valid", 32'(valid_o), 0);
        tick();
        cmp("trap_err", 32'(err_o), 1);
        cmp("trap_done", 32'(done_o), 1);
        cmp("trap_busy", 32'(busy_o), 0);
        cmp("trap_pc", 32'(rom_bus.pc), 198);
        tick();
        cmp("trap_err_held", 32'(err_o), 1);
        cmp("trap_done_end", 32'(done_o), 0);
        drive(1, 3, 0, 0, 0, 0);
        tick();
        cmp("sel3_pc", 32'(rom_bus.pc), 0);
        cmp("sel3_err", 32'(err_o), 0);
`else
        cmp("ff_valid", 32'(valid_o), 1);
        cmp("ff_instr", 32'(instr_o), 255);
        tick();
        cmp("ff_pc", 32'(rom_bus.pc), 199);
        cmp("ff_count", 32'(count_o), 57);
        cmp("ff_err", 32'(err_o), 0);
`endif

        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        cmp("final_rst_pc", 32'(rom_bus.pc), 0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
